// File: rtl/popcount_stream_if.sv
// Word-in / count-out handshake bundle for popcount_stream.
// The block under count is the slave; the source/consumer side is the master.
interface popcount_stream_if #(
  parameter int unsigned WIDTH = 32
) ();
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             out_parity;

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_count, out_parity
  );

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_count, out_parity
  );
endinterface

// File: rtl/popcount_stream.sv
// Multi-cycle population counter: takes one WIDTH-bit word, counts ones (or zeros)
// CHUNK bits per cycle and holds the result until the consumer accepts it.
module popcount_stream #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  popcount_stream_if.slave  bus,
  output logic              busy
);
  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned CW  = $clog2(WIDTH + 1);
  localparam int unsigned PW  = $clog2(CHUNK + 1);
  localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    count_q, count_d;
  logic             init_q;
  logic [PW-1:0]    chunk_pc;
  logic [CW-1:0]    sum;

  always_comb begin
    chunk_pc = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      chunk_pc = chunk_pc + PW'(shreg_q[i]);
    end
  end

  assign sum = acc_q + CW'(chunk_pc);

  // in_ready stays low until the first clock edge after reset is released.
  assign bus.in_ready   = (state_q == StIdle) && init_q;
  assign bus.out_valid  = (state_q == StDone);
  assign bus.out_count  = count_q;
  assign bus.out_parity = count_q[0];
  assign busy           = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid && bus.in_ready) begin
          // Counting zeros is counting ones of the inverted word.
          shreg_d = bus.in_mode ? ~bus.in_data : bus.in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = StCount;
        end
      end
      StCount: begin
        acc_d   = sum;
        shreg_d = shreg_q >> CHUNK;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(NCH - 1)) begin
          count_d = sum;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      init_q  <= 1'b1;
    end
  end
endmodule
